mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multi-cycle control unit for the MIPS CPU datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives every datapath mux and write enable, including the immediate extender mode (sign or zero). It also stalls on a memory-ready handshake and keeps a retired-instruction counter.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction bits [31:26], taken from the instruction register
- funct  in  6  instruction bits [5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC write enable
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = ext_imm, 11 = ext_imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = decode funct, 11 = decode opcode (immediate ops)
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ext_zero  out  1  extender mode: 1 = zero-extend, 0 = sign-extend
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- instr_count  out  32  count of retired instructions
- state  out  4  current state (debug)

## Operation
- State encoding:
  - FETCH = 0
  - DECODE = 1
  - MEMADR = 2
  - MEMRD = 3
  - MEMWB = 4
  - MEMWR = 5
  - REX = 6
  - RWB = 7
  - BRANCH = 8
  - IEX = 9
  - IWB = 10
  - JUMP = 11
  - Codes 12-15 are unreachable and go to FETCH.
- Outputs are Moore-decoded from state; pc_en in BRANCH additionally depends on zero. Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_en assert only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when it is 1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state by opcode:
    - 0x23 (lw) or 0x2B (sw) -> MEMADR
    - 0x00 (R-type) -> REX
    - 0x04 (beq) or 0x05 (bne) -> BRANCH
    - 0x08, 0x0A, 0x0C, 0x0D (addi, slti, andi, ori) -> IEX
    - 0x02 (j) -> JUMP
    - anything else -> FETCH, with illegal_op=1 for that cycle
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Goes to MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Outputs: mem_read=1, iord=1.
  - Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
- MEMWR:
  - Outputs: mem_write=1, iord=1.
  - Holds until mem_ready=1, then goes to FETCH.
- REX: alu_src_a=1, alu_src_b=00, alu_op=10; then RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01.
  - pc_en = zero for beq, ~zero for bne.
  - Next state FETCH.
- IEX: alu_src_a=1, alu_src_b=10, alu_op=11; then IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
- JUMP: pc_en=1, pc_src=10; then FETCH.
- ext_zero = 1 whenever the registered opcode is 0x0C or 0x0D, in any state; 0 otherwise.
- instr_count increments by 1 on exit from MEMWB, MEMWR (the mem_ready=1 cycle), RWB, BRANCH, IWB and JUMP. It wraps 0xFFFFFFFF -> 0. Illegal opcodes are not counted.

## Timing
- Reset: rst=1 at a rising edge sets state=FETCH and instr_count=0.
- While rst=1, pc_en, ir_write, reg_write and mem_write are forced to 0, whatever the state. Other outputs follow the FETCH decode once state is FETCH.
- Reset mid-instruction abandons the instruction without a count and restarts at FETCH.
- Cycles per instruction with mem_ready held at 1:
  - lw: 5
  - sw: 4
  - R-type: 4
  - immediate ops: 4
  - beq/bne: 3
  - j: 3
  - illegal opcode: 2
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. All outputs hold steady during the stall.
- opcode, funct and zero are sampled combinationally. The instruction register is stable from DECODE onward.

## Test plan
- rst=1 for 2 cycles, then addi (0x08) with mem_ready=1 -> states 0,1,9,10,0. reg_write=1 only in IWB. instr_count=1 after 4 cycles.
- lw with mem_ready=0 for 3 cycles in FETCH and 2 in MEMRD -> 10 cycles total. ir_write is pulsed exactly once. Outputs are stable during the stall.
- beq with zero=1, then bne with zero=1 -> pc_en=1 in BRANCH for beq and 0 for bne. instr_count increments by 2.
- ori (0x0D), then addi -> ext_zero=1 throughout ori. ext_zero=0 throughout addi.
- Opcode 0x3F -> illegal_op pulses in DECODE, returns to FETCH, instr_count unchanged.
- rst asserted during MEMWR with mem_ready=1 -> mem_write=0 that cycle, state=0 next cycle, count=0. Preload the count to 0xFFFFFFFF and retire one j -> count wraps to 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl_if.sv
// Control-unit bus for the multi-cycle MIPS datapath.
// Carries the instruction fields, ALU flag and memory handshake into the
// controller, and every datapath mux select / write enable back out, plus
// the retired-instruction counter and a debug view of the current state.
//   master : controller side (mips_multicycle_ctrl)
//   slave  : datapath side (drives instruction fields, zero, mem_ready)
interface mips_multicycle_ctrl_if;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;

  logic        pc_en;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic [1:0]  pc_src;
  logic        ext_zero;
  logic        illegal_op;
  logic [31:0] instr_count;
  logic [3:0]  state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, ext_zero,
           illegal_op, instr_count, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, alu_op, pc_src, ext_zero,
           illegal_op, instr_count, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit.
// Sequences each instruction through fetch/decode/execute/memory/write-back,
// Moore-decodes all datapath controls from the current state, stalls in
// FETCH/MEMRD/MEMWR until mem_ready, and counts retired instructions.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : mips_multicycle_ctrl_if.master (instruction fields, handshake,
//          datapath controls, instr_count, debug state)
module mips_multicycle_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  mips_multicycle_ctrl_if.master bus
);

  localparam int unsigned CNT_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEX    = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               retire;

  logic       pc_en_c, iord_c, mem_read_c, mem_write_c, ir_write_c;
  logic       reg_dst_c, mem_to_reg_c, reg_write_c, alu_src_a_c, illegal_c;
  logic [1:0] alu_src_b_c, alu_op_c, pc_src_c;

  // State and retired-instruction counter; reset abandons any instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count_d = retire ? count_q + CNT_W'(1) : count_q;

  // Next-state and Moore output decode.
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    pc_en_c      = 1'b0;
    iord_c       = 1'b0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    pc_src_c     = 2'b00;
    illegal_c    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 computed every fetch cycle; committed only when memory answers.
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while decoding.
        alu_src_b_c = 2'b11;
        case (bus.opcode)
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_RTYPE:                         state_d = S_REX;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEX;
          OP_J:                             state_d = S_JUMP;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        iord_c     = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        iord_c      = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_REX: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b10;
        state_d     = S_RWB;
      end
      S_RWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_c = 1'b1;
        alu_op_c    = 2'b01;
        pc_src_c    = 2'b01;
        // bne takes the branch on a nonzero difference, beq on zero.
        pc_en_c     = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_IEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        alu_op_c    = 2'b11;
        state_d     = S_IWB;
      end
      S_IWB: begin
        reg_write_c = 1'b1;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_en_c  = 1'b1;
        pc_src_c = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Architectural write enables are suppressed while reset is held.
  assign bus.pc_en       = pc_en_c     & ~rst;
  assign bus.ir_write    = ir_write_c  & ~rst;
  assign bus.reg_write   = reg_write_c & ~rst;
  assign bus.mem_write   = mem_write_c & ~rst;
  assign bus.iord        = iord_c;
  assign bus.mem_read    = mem_read_c;
  assign bus.reg_dst     = reg_dst_c;
  assign bus.mem_to_reg  = mem_to_reg_c;
  assign bus.alu_src_a   = alu_src_a_c;
  assign bus.alu_src_b   = alu_src_b_c;
  assign bus.alu_op      = alu_op_c;
  assign bus.pc_src      = pc_src_c;
  assign bus.illegal_op  = illegal_c;
  // Logical immediates (andi/ori) zero-extend; everything else sign-extends.
  assign bus.ext_zero    = (bus.opcode == OP_ANDI) || (bus.opcode == OP_ORI);
  assign bus.instr_count = count_q;
  assign bus.state       = 4'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: each instruction's expected
// state path is built from its cycle recipe and each cycle's controls come
// from a per-state output table.
module tb_mips_multicycle_ctrl;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [31:0] cnt_model;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  logic [16:0] act;
  assign act = {bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_src, bus.ext_zero, bus.illegal_op};

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
  endfunction

  // Expected control vector for a state number, same packing as act.
  function automatic logic [16:0] exp_out(input int s, input logic [5:0] op,
                                          input logic z, input logic mr);
    logic pe, io, mrd, mw, irw, rd, m2r, rw, asa, ez, ill;
    logic [1:0] asb, aop, psrc;
    {pe, io, mrd, mw, irw, rd, m2r, rw, asa, ez, ill} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (s)
      0:  begin mrd = 1'b1; asb = 2'b01; pe = mr; irw = mr; end
      1:  begin asb = 2'b11; ill = !is_legal(op); end
      2:  begin asa = 1'b1; asb = 2'b10; end
      3:  begin mrd = 1'b1; io = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; end
      5:  begin mw = 1'b1; io = 1'b1; end
      6:  begin asa = 1'b1; aop = 2'b10; end
      7:  begin rw = 1'b1; rd = 1'b1; end
      8:  begin asa = 1'b1; aop = 2'b01; psrc = 2'b01; pe = (op == 6'h05) ? !z : z; end
      9:  begin asa = 1'b1; asb = 2'b10; aop = 2'b11; end
      10: begin rw = 1'b1; end
      11: begin pe = 1'b1; psrc = 2'b10; end
      default: ;
    endcase
    ez = (op == 6'h0C) || (op == 6'h0D);
    return {pe, io, mrd, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, ez, ill};
  endfunction

  // Runs one instruction from FETCH: fs fetch stalls, ms memory stalls.
  task automatic exec_instr(input logic [5:0] op, input logic z, input int fs,
                            input int ms, input string tag);
    int   st_q[$];
    logic mr_q[$];
    int   ir_pulses;
    logic [16:0] exp;
    ir_pulses = 0;
    for (int i = 0; i < fs; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
    st_q.push_back(0); mr_q.push_back(1'b1);
    st_q.push_back(1); mr_q.push_back(1'($urandom));
    case (op)
      6'h23: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int i = 0; i < ms; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
        st_q.push_back(3); mr_q.push_back(1'b1);
        st_q.push_back(4); mr_q.push_back(1'($urandom));
      end
      6'h2B: begin
        st_q.push_back(2); mr_q.push_back(1'($urandom));
        for (int i = 0; i < ms; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
        st_q.push_back(5); mr_q.push_back(1'b1);
      end
      6'h00: begin
        st_q.push_back(6); mr_q.push_back(1'($urandom));
        st_q.push_back(7); mr_q.push_back(1'($urandom));
      end
      6'h04, 6'h05: begin st_q.push_back(8); mr_q.push_back(1'($urandom)); end
      6'h08, 6'h0A, 6'h0C, 6'h0D: begin
        st_q.push_back(9);  mr_q.push_back(1'($urandom));
        st_q.push_back(10); mr_q.push_back(1'($urandom));
      end
      6'h02: begin st_q.push_back(11); mr_q.push_back(1'($urandom)); end
      default: ;
    endcase

    for (int i = 0; i < st_q.size(); i++) begin
      @(negedge clk);
      bus.opcode    = op;
      bus.funct     = 6'($urandom);
      bus.zero      = z;
      bus.mem_ready = mr_q[i];
      #1;
      compared++;
      if (bus.state !== 4'(st_q[i])) begin
        mismatched++;
        $display("FAIL %s state cyc%0d: got %0d want %0d", tag, i, bus.state, st_q[i]);
      end
      exp = exp_out(st_q[i], op, z, mr_q[i]);
      compared++;
      if (act !== exp) begin
        mismatched++;
        $display("FAIL %s controls cyc%0d: got %b want %b", tag, i, act, exp);
      end
      compared++;
      if (bus.instr_count !== cnt_model) begin
        mismatched++;
        $display("FAIL %s count cyc%0d: got %0d want %0d", tag, i, bus.instr_count, cnt_model);
      end
      if (bus.ir_write === 1'b1) ir_pulses++;
      @(posedge clk);
    end
    if (is_legal(op)) cnt_model = cnt_model + 32'd1;
    #1;
    compared++;
    if (bus.state !== 4'd0) begin
      mismatched++;
      $display("FAIL %s end_state: got %0d want 0", tag, bus.state);
    end
    compared++;
    if (bus.instr_count !== cnt_model) begin
      mismatched++;
      $display("FAIL %s end_count: got %0d want %0d", tag, bus.instr_count, cnt_model);
    end
    compared++;
    if (ir_pulses !== 1) begin
      mismatched++;
      $display("FAIL %s ir_pulses: got %0d want 1", tag, ir_pulses);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    compared++;
    if (bus.state !== 4'd0) begin mismatched++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    compared++;
    if (bus.instr_count !== 32'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", bus.instr_count); end
    compared++;
    if ({bus.pc_en, bus.ir_write, bus.reg_write, bus.mem_write} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_enables: got %b want 0000",
               {bus.pc_en, bus.ir_write, bus.reg_write, bus.mem_write});
    end
    compared++;
    if (bus.mem_read !== 1'b1) begin mismatched++; $display("FAIL reset_mem_read: got %b want 1", bus.mem_read); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_model = 32'd0;
  endtask

  task automatic test_addi();
    exec_instr(6'h08, 1'b0, 0, 0, "addi");
  endtask

  task automatic test_lw_stall();
    exec_instr(6'h23, 1'b0, 3, 2, "lw_stall");
  endtask

  task automatic test_branch();
    logic [31:0] start;
    start = cnt_model;
    exec_instr(6'h04, 1'b1, 0, 0, "beq_z1");
    exec_instr(6'h05, 1'b1, 0, 0, "bne_z1");
    compared++;
    if (bus.instr_count !== start + 32'd2) begin
      mismatched++;
      $display("FAIL branch_delta: got %0d want %0d", bus.instr_count, start + 32'd2);
    end
  endtask

  task automatic test_ext_zero();
    exec_instr(6'h0D, 1'b0, 1, 0, "ori");
    exec_instr(6'h08, 1'b0, 0, 0, "addi_ext");
  endtask

  task automatic test_illegal();
    exec_instr(6'h3F, 1'b0, 0, 0, "illegal");
  endtask

  task automatic test_reset_midinstr();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    compared++;
    if (bus.state !== 4'd5) begin mismatched++; $display("FAIL rstmid_pre_state: got %0d want 5", bus.state); end
    rst = 1'b1; bus.mem_ready = 1'b1;
    #1;
    compared++;
    if (bus.mem_write !== 1'b0) begin mismatched++; $display("FAIL rstmid_mem_write: got %b want 0", bus.mem_write); end
    compared++;
    if (bus.iord !== 1'b1) begin mismatched++; $display("FAIL rstmid_iord: got %b want 1", bus.iord); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_model = 32'd0;
    compared++;
    if (bus.state !== 4'd0) begin mismatched++; $display("FAIL rstmid_state: got %0d want 0", bus.state); end
    compared++;
    if (bus.instr_count !== 32'd0) begin mismatched++; $display("FAIL rstmid_count: got %0d want 0", bus.instr_count); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    force dut.count_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.count_q;
    #1;
    cnt_model = 32'hFFFF_FFFF;
    compared++;
    if (bus.instr_count !== cnt_model) begin
      mismatched++;
      $display("FAIL wrap_preload: got %h want %h", bus.instr_count, cnt_model);
    end
    exec_instr(6'h02, 1'b0, 0, 0, "j_wrap");
    compared++;
    if (bus.instr_count !== 32'd0) begin
      mismatched++;
      $display("FAIL wrap_zero: got %h want 0", bus.instr_count);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [11];
    logic [5:0] op;
    ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3F};
    for (int n = 0; n < 40; n++) begin
      op = ops[$urandom_range(0, 10)];
      exec_instr(op, 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cnt_model  = 32'd0;
    test_reset();
    test_addi();
    test_lw_stall();
    test_branch();
    test_ext_zero();
    test_illegal();
    test_reset_midinstr();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
